seq_restoring_divider: RTL and testbench

//   Sequential unsigned restoring divider; inverse of the 4b x 4b array multiplier.

---
 rtl/seq_restoring_divider.sv | 188 ++++++++++++++++++
 tb/tb_seq_restoring_divider.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// ---------------------------------------------------------------------------
// seq_restoring_divider
//   Sequential unsigned restoring divider: DW-bit dividend / VW-bit divisor,
//   one quotient bit retired per clock, valid/ready handshake on both sides.
//   dividend = quotient*divisor + remainder, remainder < divisor.
//   Divide-by-zero returns quotient = all ones, remainder = dividend[VW-1:0]
//   and flags div_zero.
//
//   Optional build macro: DIV_SELFCHECK_EN
//     Adds output check_err, an arithmetic self-check of the result that is
//     registered alongside the outputs; out_valid is delayed one cycle.
// ---------------------------------------------------------------------------
module seq_restoring_divider #(
   parameter int DW = 8,
   parameter int VW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          div_zero
`ifdef DIV_SELFCHECK_EN
   ,
   output logic          check_err
`endif
);

   localparam int CW = $clog2(DW + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] count;

   // Working registers. The stored partial remainder is always < divisor after
   // the restore step, so VW bits hold it; the VW+1-bit value exists only as
   // the shifted intermediate inside div_step.
   logic [DW-1:0] dvd;
   logic [VW-1:0] dsr;
   logic [VW-1:0] pr;
   logic [DW-1:0] q;

`ifdef DIV_SELFCHECK_EN
   logic [DW-1:0] dvd_orig;
   logic          done_ph;
`endif

   logic          accept;
   logic          step_en;
   logic [VW+1:0] step_res;

   // One restoring step: shift in the next dividend bit, trial-subtract the
   // divisor, and restore if it would go negative. Returns {new_pr, qbit}.
   function automatic logic [VW+1:0] div_step(input logic [VW-1:0] pr_in,
                                              input logic          bit_in,
                                              input logic [VW-1:0] d);
      logic [VW:0] t;
      logic [VW:0] diff;
      t    = {pr_in, bit_in};
      diff = t - {1'b0, d};
      if (t >= {1'b0, d})
         div_step = {diff, 1'b1};
      else
         div_step = {t, 1'b0};
   endfunction

`ifdef DIV_SELFCHECK_EN
   // Result consistency: q*d + r must reproduce the dividend and r < d.
   // A zero divisor has its own defined result and is never flagged.
   function automatic logic div_check(input logic [DW-1:0] n,
                                      input logic [VW-1:0] d,
                                      input logic [DW-1:0] qq,
                                      input logic [VW-1:0] r);
      logic [DW+VW-1:0] prod;
      prod = ({{VW{1'b0}}, qq} * {{DW{1'b0}}, d}) + {{DW{1'b0}}, r};
      div_check = (d != '0) && ((prod != {{VW{1'b0}}, n}) || (r >= d));
   endfunction
`endif

   assign accept   = (state == S_IDLE) && in_valid && in_ready;
   assign step_en  = (state == S_RUN) && (count != '0);
   assign step_res = div_step(pr, dvd[DW-1], dsr);

   // Datapath: load operands on accept, then one shift/subtract per RUN cycle.
   always_ff @(posedge clk) begin
      if (accept) begin
         dvd <= dividend;
         dsr <= divisor;
         if (divisor == '0) begin
            q  <= '1;
            pr <= dividend[VW-1:0];
         end else begin
            q  <= '0;
            pr <= '0;
         end
`ifdef DIV_SELFCHECK_EN
         dvd_orig <= dividend;
`endif
      end else if (step_en) begin
         pr  <= step_res[VW:1];
         q   <= {q[DW-2:0], step_res[0]};
         dvd <= {dvd[DW-2:0], 1'b0};
      end
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         count     <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         div_zero  <= 1'b0;
`ifdef DIV_SELFCHECK_EN
         done_ph   <= 1'b0;
         check_err <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  in_ready <= 1'b0;
                  count    <= CW'(DW);
`ifdef DIV_SELFCHECK_EN
                  done_ph  <= 1'b0;
`endif
                  if (divisor != '0)
                     state <= S_RUN;
                  else
                     state <= S_DONE;
               end
            end

            S_RUN: begin
               // The last iteration happens on the same edge that enters DONE.
               if (count != '0)
                  count <= count - CW'(1);
               if (count <= CW'(1))
                  state <= S_DONE;
            end

            S_DONE: begin
               if (!out_valid) begin
`ifdef DIV_SELFCHECK_EN
                  if (!done_ph) begin
                     done_ph   <= 1'b1;
                     quotient  <= q;
                     remainder <= pr;
                     div_zero  <= (dsr == '0);
                     check_err <= div_check(dvd_orig, dsr, q, pr);
                  end else begin
                     out_valid <= 1'b1;
                  end
`else
                  out_valid <= 1'b1;
                  quotient  <= q;
                  remainder <= pr;
                  div_zero  <= (dsr == '0);
`endif
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end

            default: begin
               state     <= S_IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_restoring_divider
//   Directed and randomized bench for seq_restoring_divider against a plain
//   arithmetic reference (/ and %). Honors DIV_SELFCHECK_EN if defined.
// ---------------------------------------------------------------------------
module tb_seq_restoring_divider;

   localparam int DW = 8;
   localparam int VW = 4;
`ifdef DIV_SELFCHECK_EN
   localparam int LAT_NZ = DW + 2;
   localparam int LAT_Z  = 2;
`else
   localparam int LAT_NZ = DW + 1;
   localparam int LAT_Z  = 1;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] dividend = '0;
   logic [VW-1:0] divisor = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          div_zero;
`ifdef DIV_SELFCHECK_EN
   logic          check_err;
`endif

   int checks = 0;
   int errors = 0;

   seq_restoring_divider #(.DW(DW), .VW(VW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
`ifdef DIV_SELFCHECK_EN
      ,
      .check_err (check_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: ordinary integer division; zero divisor has a fixed answer.
   task automatic model(input logic [DW-1:0] a, input logic [VW-1:0] b,
                        output logic [DW-1:0] eq, output logic [VW-1:0] er,
                        output logic ez);
      if (b == '0) begin
         eq = '1;
         er = a[VW-1:0];
         ez = 1'b1;
      end else begin
         eq = a / {{(DW-VW){1'b0}}, b};
         er = VW'(a % {{(DW-VW){1'b0}}, b});
         ez = 1'b0;
      end
   endtask

   // One full transaction. rand_rdy applies random backpressure; detail adds
   // latency and handshake-timing checks.
   task automatic do_op(input string tag, input logic [DW-1:0] a, input logic [VW-1:0] b,
                        input bit rand_rdy, input bit detail);
      logic [DW-1:0] eq;
      logic [VW-1:0] er;
      logic          ez;
      int            w;
      int            lat;
      bit            done;
      model(a, b, eq, er, ez);
      w = 0;
      while (!in_ready && w < 50) begin
         tick();
         w++;
      end
      if (detail || !in_ready) chk({tag, "_in_ready_before"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      dividend = a;
      divisor  = b;
      tick();
      in_valid = 1'b0;
      dividend = DW'($urandom);
      divisor  = VW'($urandom);
      if (detail) chk({tag, "_in_ready_after_accept"}, 32'(in_ready), 32'd0);
      lat = 0;
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
      end
      if (detail || !out_valid) chk({tag, "_out_valid_seen"}, 32'(out_valid), 32'd1);
      if (detail) chk({tag, "_latency"}, 32'(lat), (b == '0) ? 32'(LAT_Z) : 32'(LAT_NZ));
      done = 1'b0;
      w = 0;
      while (!done && w < 100) begin
         out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         if (out_ready) begin
            chk({tag, "_quotient"}, 32'(quotient), 32'(eq));
            chk({tag, "_remainder"}, 32'(remainder), 32'(er));
            chk({tag, "_div_zero"}, 32'(div_zero), 32'(ez));
`ifdef DIV_SELFCHECK_EN
            chk({tag, "_check_err"}, 32'(check_err), 32'd0);
`endif
            done = 1'b1;
         end
         tick();
         w++;
      end
      out_ready = 1'b0;
      if (!done) chk({tag, "_handshake_timeout"}, 32'(done), 32'd1);
      if (detail) begin
         chk({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
         chk({tag, "_in_ready_return"}, 32'(in_ready), 32'd1);
      end
   endtask

   initial begin
      // Reset state
      rst_n = 1'b0;
      tick();
      tick();
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_quotient", 32'(quotient), 32'd0);
      chk("rst_remainder", 32'(remainder), 32'd0);
      chk("rst_div_zero", 32'(div_zero), 32'd0);
      rst_n = 1'b1;
      tick();

      // Directed cases
      do_op("d200_7", 8'd200, 4'd7, 1'b0, 1'b1);
      chk("d200_7_known_q", 32'(quotient), 32'd28);
      chk("d200_7_known_r", 32'(remainder), 32'd4);
      do_op("d255_15", 8'd255, 4'd15, 1'b0, 1'b1);
      do_op("d255_1", 8'd255, 4'd1, 1'b0, 1'b1);
      do_op("d5_9", 8'd5, 4'd9, 1'b0, 1'b1);
      do_op("d0_3", 8'd0, 4'd3, 1'b0, 1'b1);
      do_op("d13_0", 8'd13, 4'd0, 1'b0, 1'b1);
      chk("d13_0_known_q", 32'(quotient), 32'd255);

      // Backpressure: 100/3 held for 20 cycles while in_valid pulses are ignored
      begin
         int w;
         in_valid = 1'b1;
         dividend = 8'd100;
         divisor  = 4'd3;
         tick();
         in_valid = 1'b0;
         w = 0;
         while (!out_valid && w < 100) begin
            tick();
            w++;
         end
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         for (int i = 0; i < 20; i++) begin
            in_valid = 1'(i % 2);
            dividend = 8'd7;
            divisor  = 4'd2;
            tick();
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_q", 32'(quotient), 32'd33);
            chk("bp_hold_r", 32'(remainder), 32'd1);
            chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         chk("bp_release_valid", 32'(out_valid), 32'd0);
         chk("bp_release_in_ready", 32'(in_ready), 32'd1);
         for (int i = 0; i < 12; i++) tick();
         chk("bp_no_phantom_op", 32'(out_valid), 32'd0);
      end

      // Reset during the 4th RUN cycle of 200/7
      in_valid = 1'b1;
      dividend = 8'd200;
      divisor  = 4'd7;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      #2;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_quotient", 32'(quotient), 32'd0);
      chk("midrst_remainder", 32'(remainder), 32'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      chk("midrst_no_stale_valid", 32'(out_valid), 32'd0);
      do_op("d77_6", 8'd77, 4'd6, 1'b0, 1'b1);
      chk("d77_6_known_q", 32'(quotient), 32'd12);
      chk("d77_6_known_r", 32'(remainder), 32'd5);

      // Random operands with random backpressure
      for (int i = 0; i < 40; i++)
         do_op("rand", DW'($urandom), VW'($urandom), 1'b1, 1'b1);

      // Exhaustive sweep, back-to-back, random out_ready
      for (int a = 0; a < 256; a++)
         for (int b = 0; b < 16; b++)
            do_op("sweep", DW'(a), VW'(b), 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
